wb_arb_mux: RTL and testbench

- Parametrised successor to the 4:1 combinational bus-to-regfile select.
- Arbitrates NSRC write-back sources (ALU, load unit, immediate/move path, I/O) onto the single register-file write port.
- Arbitration is fixed-priority or round-robin.
- Source-side handshake is req/grant. Result is held in a one-entry output register with valid/ready toward the register file.
- Sits between the execute/memory stages and the regfile write port.

---
 rtl/wb_arb_mux_pkg.sv | 15 +
 rtl/wb_arb_mux_rr_arbiter.sv | 47 ++++
 rtl/wb_arb_mux.sv | 74 +++++++
 tb/tb_wb_arb_mux.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/wb_arb_mux_pkg.sv
// Shared constants for the write-back arbiter: default widths, source slots and arbitration modes.
package wb_arb_mux_pkg;

  localparam int DATAWIDTH_DEF = 16;
  localparam int ADDRW_DEF     = 4;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_IMM = 2;
  localparam int SRC_IO  = 3;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/wb_arb_mux_rr_arbiter.sv
// Combinational arbiter: fixed priority from index 0, or round-robin search starting at ptr.
module rr_arbiter
  import wb_arb_mux_pkg::*;
#(
  parameter int NSRC     = 4,
  parameter int SELW     = 2,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic [NSRC-1:0] req,
  input  logic [SELW-1:0] ptr,
  input  logic            enable,
  output logic [NSRC-1:0] gnt,
  output logic [SELW-1:0] idx
);

  localparam logic [SELW:0] NSRC_W = (SELW+1)'(NSRC);

  logic [SELW:0]   pos;
  logic [SELW-1:0] sel;
  logic            found;

  // Walk the sources once, wrapping modulo NSRC so unused index codes are never visited.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    sel   = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (ARB_MODE == ARB_RR) begin
        pos = {1'b0, ptr} + (SELW+1)'(i);
      end else begin
        pos = (SELW+1)'(i);
      end
      if (pos >= NSRC_W) begin
        pos = pos - NSRC_W;
      end
      sel = pos[SELW-1:0];
      if (enable && !found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        idx      = sel;
      end
    end
  end

endmodule

// File: rtl/wb_arb_mux.sv
// Arbitrates NSRC write-back sources onto the single regfile write port through a
// one-entry valid/ready output register.
module wb_arb_mux
  import wb_arb_mux_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int NSRC      = 4,
  parameter int SELW      = 2,
  parameter int ADDRW     = ADDRW_DEF,
  parameter int ARB_MODE  = ARB_FIXED
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NSRC-1:0]           src_req,
  input  logic [NSRC*DATAWIDTH-1:0] src_data,
  input  logic [NSRC*ADDRW-1:0]     src_addr,
  output logic [NSRC-1:0]           src_gnt,
  output logic [SELW-1:0]           gnt_id,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [ADDRW-1:0]          wb_addr,
  output logic [DATAWIDTH-1:0]      wb_data,
  output logic [SELW-1:0]           wb_src
);

  localparam logic [SELW-1:0] LAST_SRC = SELW'(NSRC - 1);

  logic            free;
  logic            arb_en;
  logic            grant;
  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] sel;
  logic [NSRC-1:0] gnt;

  // Gating with rst_n keeps grants silent while reset is held, even mid-cycle.
  assign free   = !wb_valid || wb_ready;
  assign arb_en = rst_n && free;

  rr_arbiter #(
    .NSRC     (NSRC),
    .SELW     (SELW),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .req    (src_req),
    .ptr    (rr_ptr),
    .enable (arb_en),
    .gnt    (gnt),
    .idx    (sel)
  );

  assign src_gnt = gnt;
  assign gnt_id  = sel;
  assign grant   = |gnt;

  // Output register: reload on grant, otherwise drain when the regfile accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      wb_src   <= '0;
      rr_ptr   <= '0;
    end else if (grant) begin
      wb_valid <= 1'b1;
      wb_data  <= src_data[sel*DATAWIDTH +: DATAWIDTH];
      wb_addr  <= src_addr[sel*ADDRW +: ADDRW];
      wb_src   <= sel;
      rr_ptr   <= (sel == LAST_SRC) ? '0 : sel + 1'b1;
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arb_mux.sv
// Directed bench for wb_arb_mux: one fixed-priority and one round-robin instance.
module tb_wb_arb_mux;

  localparam int DW = 16;
  localparam int NS = 4;
  localparam int SW = 2;
  localparam int AW = 4;

  logic              clk;
  logic              rst_n;
  logic [NS-1:0]     src_req;
  logic [NS*DW-1:0]  src_data;
  logic [NS*AW-1:0]  src_addr;
  logic              wb_ready;

  logic [NS-1:0] gnt_f, gnt_r;
  logic [SW-1:0] gid_f, gid_r, src_f, src_r;
  logic          vld_f, vld_r;
  logic [AW-1:0] addr_f, addr_r;
  logic [DW-1:0] data_f, data_r;

  int total;
  int bad;

  wb_arb_mux #(.DATAWIDTH(DW), .NSRC(NS), .SELW(SW), .ADDRW(AW), .ARB_MODE(0)) dut_f (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_data(src_data), .src_addr(src_addr),
    .src_gnt(gnt_f), .gnt_id(gid_f), .wb_valid(vld_f), .wb_ready(wb_ready),
    .wb_addr(addr_f), .wb_data(data_f), .wb_src(src_f)
  );

  wb_arb_mux #(.DATAWIDTH(DW), .NSRC(NS), .SELW(SW), .ADDRW(AW), .ARB_MODE(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_data(src_data), .src_addr(src_addr),
    .src_gnt(gnt_r), .gnt_id(gid_r), .wb_valid(vld_r), .wb_ready(wb_ready),
    .wb_addr(addr_r), .wb_data(data_r), .wb_src(src_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [DW-1:0] d, input logic [AW-1:0] a);
    src_data[i*DW +: DW] = d;
    src_addr[i*AW +: AW] = a;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wb_ready = 1'b1; src_req = 4'b1111;
    set_src(0, 16'h1234, 4'h5);
    set_src(1, 16'h1111, 4'h6);
    set_src(2, 16'h2222, 4'h7);
    set_src(3, 16'h3333, 4'h8);
    step(); step();
    total++; if (gnt_f !== 4'b0000) begin bad++; $display("FAIL rst_gnt got=%b want=0000", gnt_f); end
    total++; if (vld_f !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", vld_f); end
    total++; if (data_f !== 16'h0000) begin bad++; $display("FAIL rst_data got=%h want=0000", data_f); end
    total++; if (gnt_r !== 4'b0000) begin bad++; $display("FAIL rst_gnt_rr got=%b want=0000", gnt_r); end
    rst_n = 1'b1;
    #1;
    total++; if (gnt_f !== 4'b0001) begin bad++; $display("FAIL first_gnt got=%b want=0001", gnt_f); end
    step();
    total++; if (data_f !== 16'h1234) begin bad++; $display("FAIL first_data got=%h want=1234", data_f); end
    total++; if (addr_f !== 4'h5) begin bad++; $display("FAIL first_addr got=%h want=5", addr_f); end
    total++; if (src_f !== 2'd0 || vld_f !== 1'b1) begin bad++; $display("FAIL first_src got=%0d/%b want=0/1", src_f, vld_f); end
  endtask

  task automatic test_fixed_priority();
    src_req = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (gnt_f !== 4'b0010 || gid_f !== 2'd1) begin bad++; $display("FAIL fixed_gnt c=%0d got=%b/%0d want=0010/1", c, gnt_f, gid_f); end
      step();
      total++; if (src_f !== 2'd1 || data_f !== 16'h1111) begin bad++; $display("FAIL fixed_out c=%0d got=%0d/%h want=1/1111", c, src_f, data_f); end
    end
    src_req = 4'b1000;
    #1;
    total++; if (gnt_f !== 4'b1000 || gid_f !== 2'd3) begin bad++; $display("FAIL fixed_gnt3 got=%b/%0d want=1000/3", gnt_f, gid_f); end
    step();
    total++; if (src_f !== 2'd3 || data_f !== 16'h3333 || addr_f !== 4'h8) begin bad++; $display("FAIL fixed_out3 got=%0d/%h/%h want=3/3333/8", src_f, data_f, addr_f); end
  endtask

  task automatic test_drain();
    src_req = 4'b0000; wb_ready = 1'b1;
    #1;
    total++; if (gnt_f !== 4'b0000 || gid_f !== 2'd0) begin bad++; $display("FAIL drain_gnt got=%b/%0d want=0000/0", gnt_f, gid_f); end
    step();
    total++; if (vld_f !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b want=0", vld_f); end
    total++; if (data_f !== 16'h3333 || addr_f !== 4'h8) begin bad++; $display("FAIL drain_hold got=%h/%h want=3333/8", data_f, addr_f); end
  endtask

  task automatic test_backpressure();
    set_src(0, 16'hBEEF, 4'h2);
    src_req = 4'b0001; wb_ready = 1'b1;
    step();
    total++; if (vld_f !== 1'b1 || data_f !== 16'hBEEF) begin bad++; $display("FAIL bp_load got=%b/%h want=1/beef", vld_f, data_f); end
    src_req = 4'b0100; wb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (gnt_f !== 4'b0000) begin bad++; $display("FAIL bp_gnt c=%0d got=%b want=0000", c, gnt_f); end
      step();
      total++; if (data_f !== 16'hBEEF || vld_f !== 1'b1 || src_f !== 2'd0) begin bad++; $display("FAIL bp_hold c=%0d got=%h/%b/%0d want=beef/1/0", c, data_f, vld_f, src_f); end
    end
    wb_ready = 1'b1;
    #1;
    total++; if (gnt_f !== 4'b0100) begin bad++; $display("FAIL bp_release_gnt got=%b want=0100", gnt_f); end
    step();
    total++; if (data_f !== 16'h2222 || src_f !== 2'd2 || addr_f !== 4'h7) begin bad++; $display("FAIL bp_release_out got=%h/%0d/%h want=2222/2/7", data_f, src_f, addr_f); end
    src_req = 4'b0000;
    step();
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    src_req = 4'b1111; wb_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      total++; if (src_r !== SW'(c % NS) || vld_r !== 1'b1) begin bad++; $display("FAIL rr_seq c=%0d got=%0d/%b want=%0d/1", c, src_r, vld_r, c % NS); end
    end
    src_req = 4'b0000;
    step();
  endtask

  task automatic test_mid_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    src_req = 4'b0100;
    step();
    total++; if (src_r !== 2'd2 || vld_r !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0d/%b want=2/1", src_r, vld_r); end
    src_req = 4'b1111;
    #1;
    total++; if (gnt_r !== 4'b1000) begin bad++; $display("FAIL mid_ptr_gnt got=%b want=1000", gnt_r); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (vld_r !== 1'b0 || gnt_r !== 4'b0000) begin bad++; $display("FAIL mid_rst got=%b/%b want=0/0000", vld_r, gnt_r); end
    rst_n = 1'b1;
    #1;
    total++; if (gnt_r !== 4'b0001) begin bad++; $display("FAIL mid_after_gnt got=%b want=0001", gnt_r); end
    step();
    total++; if (src_r !== 2'd0 || data_r !== 16'hBEEF) begin bad++; $display("FAIL mid_after_out got=%0d/%h want=0/beef", src_r, data_r); end
  endtask

  initial begin
    total = 0; bad = 0;
    src_req = '0; src_data = '0; src_addr = '0; wb_ready = 1'b0; rst_n = 1'b0;
    test_reset();
    test_fixed_priority();
    test_drain();
    test_backpressure();
    test_round_robin();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
